// File: rtl/dct_pkg.sv
// Shared DCT constants and the MSB-first element extractor used on 96-bit row/column buses.
package dct_pkg;
  localparam int DCT_N      = 8;
  localparam int DCT_ELEM_W = 12;
  localparam int DCT_IDX_W  = $clog2(DCT_N);
  localparam int DCT_BUS_W  = DCT_N * DCT_ELEM_W;

  // Element k sits at the top of the bus for k=0.
  function automatic logic [DCT_ELEM_W-1:0] elem(input logic [DCT_BUS_W-1:0] bus,
                                                 input logic [DCT_IDX_W-1:0] k);
    return bus[DCT_BUS_W-1-DCT_ELEM_W*int'(k) -: DCT_ELEM_W];
  endfunction
endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: whole-row write port and a combinational column read mux.
module dct_tp_bank
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [DCT_IDX_W-1:0] waddr_i,
  input  logic [DCT_BUS_W-1:0] wdata_i,
  input  logic [DCT_IDX_W-1:0] raddr_i,
  output logic [DCT_BUS_W-1:0] rdata_o
);
  logic [DCT_BUS_W-1:0] mem_q [DCT_N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output element r is column raddr_i of stored row r.
  for (genvar r = 0; r < DCT_N; r++) begin : g_col
    assign rdata_o[DCT_BUS_W-1-DCT_ELEM_W*r -: DCT_ELEM_W] = elem(mem_q[r], raddr_i);
  end
endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer: rows in, columns out, one per clk. Define DCT_TP_SAT8_EN to
// clamp each output element to [-128,127] (sign-extended) in the output mux.
module dct_transpose_buf
  import dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DCT_BUS_W-1:0] row_in,
  input  logic                 row_valid,
  output logic                 row_ready,
  output logic [DCT_BUS_W-1:0] col_out,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic [DCT_IDX_W-1:0] col_idx,
  output logic                 col_last
);
  localparam logic [DCT_IDX_W-1:0] LAST = DCT_IDX_W'(DCT_N-1);

  logic [1:0]                 full_q, full_d;
  logic                       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [DCT_IDX_W-1:0]       wr_row_q, wr_row_d, col_idx_q, col_idx_d;
  logic [1:0][DCT_BUS_W-1:0]  bank_rd;
  logic [DCT_BUS_W-1:0]       rd_bus;
  logic [DCT_ELEM_W-1:0]      elt;
  logic                       row_fire, col_fire;

  assign row_ready = !full_q[wr_bank_q];
  assign col_valid = full_q[rd_bank_q];
  assign row_fire  = row_valid && row_ready;
  assign col_fire  = col_valid && col_ready;
  assign col_idx   = col_idx_q;
  assign col_last  = col_valid && (col_idx_q == LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank u_bank (
      .clk     (clk),
      .we_i    (row_fire && !flush && !rst && (wr_bank_q == 1'(b))),
      .waddr_i (wr_row_q),
      .wdata_i (row_in),
      .raddr_i (col_idx_q),
      .rdata_o (bank_rd[b])
    );
  end

  assign rd_bus = bank_rd[rd_bank_q];

`ifdef DCT_TP_SAT8_EN
  function automatic logic [DCT_ELEM_W-1:0] sat8(input logic [DCT_ELEM_W-1:0] x);
    logic [DCT_ELEM_W-8:0] hi;
    hi = x[DCT_ELEM_W-1:7];
    if (hi == '0 || hi == '1) return x;
    return x[DCT_ELEM_W-1] ? {{(DCT_ELEM_W-7){1'b1}}, 7'h00} : {{(DCT_ELEM_W-7){1'b0}}, 7'h7F};
  endfunction
`endif

  always_comb begin
    col_out = '0;
    elt     = '0;
    if (col_valid) begin
      for (int r = 0; r < DCT_N; r++) begin
        elt = elem(rd_bus, DCT_IDX_W'(r));
`ifdef DCT_TP_SAT8_EN
        elt = sat8(elt);
`endif
        col_out[DCT_BUS_W-1-DCT_ELEM_W*r -: DCT_ELEM_W] = elt;
      end
    end
  end

  // Write and read always target different banks, so both updates to full_d can apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    col_idx_d = col_idx_q;
    if (row_fire) begin
      wr_row_d = wr_row_q + 1'b1;
      if (wr_row_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_row_d          = '0;
      end
    end
    if (col_fire) begin
      col_idx_d = col_idx_q + 1'b1;
      if (col_idx_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        col_idx_d         = '0;
      end
    end
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_row_d  = '0;
      col_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      col_idx_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      col_idx_q <= col_idx_d;
    end
  end
endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: identity, streaming, backpressure, extremes, flush, reset.
module tb_dct_transpose_buf;
  logic        clk = 1'b0;
  logic        rst, flush, row_valid, col_ready;
  logic [95:0] row_in;
  logic        row_ready, col_valid, col_last;
  logic [95:0] col_out;
  logic [2:0]  col_idx;
  int          checks = 0;
  int          errors = 0;

  dct_transpose_buf dut (
    .clk(clk), .rst(rst), .flush(flush),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .col_out(col_out), .col_valid(col_valid), .col_ready(col_ready),
    .col_idx(col_idx), .col_last(col_last)
  );

  always #5 clk = ~clk;

  // Test data: block 3 carries signed extremes in rows 0..2.
  function automatic logic [11:0] val(int blk, int r, int c);
    if (blk == 3) begin
      if (r == 0) return 12'h800;
      if (r == 1) return 12'h7FF;
      if (r == 2) return 12'h005;
    end
    return 12'(16*r + c + 256*blk);
  endfunction

  function automatic logic [11:0] expv(logic [11:0] x);
`ifdef DCT_TP_SAT8_EN
    if ($signed(x) > 127)  return 12'h07F;
    if ($signed(x) < -128) return 12'hF80;
`endif
    return x;
  endfunction

  function automatic logic [95:0] rowv(int blk, int r);
    logic [95:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) b[95-12*c -: 12] = val(blk, r, c);
    return b;
  endfunction

  function automatic logic [95:0] colv(int blk, int c);
    logic [95:0] b;
    b = '0;
    for (int r = 0; r < 8; r++) b[95-12*r -: 12] = expv(val(blk, r, c));
    return b;
  endfunction

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; row_valid = 1'b0; col_ready = 1'b0; row_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_block(int blk);
    for (int r = 0; r < 8; r++) begin
      row_valid = 1'b1;
      row_in    = rowv(blk, r);
      chk("send_rdy", row_ready, 1);
      tick();
    end
    row_valid = 1'b0;
  endtask

  task automatic expect_cols(int blk);
    for (int c = 0; c < 8; c++) begin
      col_ready = 1'b1;
      chk("cols_cv", col_valid, 1);
      chk("cols_idx", col_idx, c);
      chk("cols_out", col_out, colv(blk, c));
      chk("cols_last", col_last, c == 7);
      tick();
    end
    col_ready = 1'b0;
    chk("cols_end_cv", col_valid, 0);
    chk("cols_end_out", col_out, 0);
  endtask

  initial begin
    int blk, idx;
    logic ev;

    // Reset state
    rst = 1'b1; flush = 1'b0; row_valid = 1'b0; col_ready = 1'b0; row_in = '0;
    tick(); tick();
    chk("rst_rdy", row_ready, 1);
    chk("rst_cv", col_valid, 0);
    chk("rst_out", col_out, 0);
    chk("rst_last", col_last, 0);
    chk("rst_idx", col_idx, 0);
    rst = 1'b0;

    // Identity + streaming: 3 blocks back-to-back, columns start 1 cycle after the 8th row
    for (int t = 0; t < 34; t++) begin
      row_valid = (t < 24);
      row_in    = (t < 24) ? rowv(t/8, t%8) : '0;
      col_ready = 1'b1;
      if (t < 24) chk("stream_rdy", row_ready, 1);
      ev = (t >= 8 && t < 32);
      chk("stream_cv", col_valid, ev);
      if (ev) begin
        chk("stream_out", col_out, colv((t-8)/8, (t-8)%8));
        chk("stream_idx", col_idx, (t-8)%8);
        chk("stream_last", col_last, ((t-8)%8) == 7);
      end
      tick();
    end
    row_valid = 1'b0;

    // Backpressure: col_ready low for 20 cycles, 17th row stalls until bank 0 drains
    do_reset();
    for (int t = 0; t < 45; t++) begin
      int ridx;
      ridx      = (t < 16) ? t : ((t < 28) ? 16 : t - 12);
      row_valid = (t < 36);
      row_in    = rowv(ridx/8, ridx%8);
      col_ready = (t >= 20);
      if (t < 36) chk("bp_rdy", row_ready, !(t >= 16 && t < 28));
      ev = (t >= 8 && t < 44);
      chk("bp_cv", col_valid, ev);
      if (ev) begin
        if (t < 20)      begin blk = 0; idx = 0;      end
        else if (t < 28) begin blk = 0; idx = t - 20; end
        else if (t < 36) begin blk = 1; idx = t - 28; end
        else             begin blk = 2; idx = t - 36; end
        chk("bp_out", col_out, colv(blk, idx));
        chk("bp_idx", col_idx, idx);
      end
      tick();
    end
    row_valid = 1'b0; col_ready = 1'b0;

    // Signed extremes pass through (or clamp when saturation is built in)
    do_reset();
    send_block(3);
    expect_cols(3);

    // Flush after 5 rows, with a concurrent row offered in the flush cycle
    do_reset();
    for (int r = 0; r < 5; r++) begin
      row_valid = 1'b1; row_in = rowv(2, r);
      tick();
    end
    flush = 1'b1; row_in = rowv(2, 5);
    tick();
    flush = 1'b0; row_valid = 1'b0;
    chk("fl1_cv", col_valid, 0);
    chk("fl1_rdy", row_ready, 1);
    chk("fl1_idx", col_idx, 0);
    send_block(1);
    expect_cols(1);

    // Flush mid-read at col_idx 3
    send_block(2);
    for (int c = 0; c < 3; c++) begin
      col_ready = 1'b1;
      chk("fl2_pre_out", col_out, colv(2, c));
      tick();
    end
    chk("fl2_idx3", col_idx, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0; col_ready = 1'b0;
    chk("fl2_cv", col_valid, 0);
    chk("fl2_rdy", row_ready, 1);
    chk("fl2_idx", col_idx, 0);
    send_block(0);
    expect_cols(0);

    // Reset with both banks full
    send_block(1);
    send_block(2);
    chk("full_rdy", row_ready, 0);
    chk("full_cv", col_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_rdy", row_ready, 1);
    chk("rst2_cv", col_valid, 0);
    chk("rst2_out", col_out, 0);
    chk("rst2_last", col_last, 0);
    chk("rst2_idx", col_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
